// File: rtl/jk_excite_pkg.sv
// Shared definitions for the JK bank driver: FSM encoding and J/K excitation codes.
// jk_code returns {J,K} for one bit, given the shadow state and the target state.
package jk_excite_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DRIVE  = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_VERIFY = 3'd3;
   localparam logic [2:0] S_ERROR  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_DRIVE  = S_DRIVE,
      ST_SETTLE = S_SETTLE,
      ST_VERIFY = S_VERIFY,
      ST_ERROR  = S_ERROR
   } state_t;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_TOG  = 2'b11;

   function automatic logic [1:0] jk_code(input logic s, input logic t, input logic tog);
      if (s == t)
         return JK_HOLD;
      else if (tog)
         return JK_TOG;
      else if (t)
         return JK_SET;
      else
         return JK_RST;
   endfunction

endpackage

// File: rtl/jk_excite_if.sv
// Control-side handshake plus the J/K/E and feedback connections to the flop bank.
// Signal names are written from the driver's point of view (i_ = into the driver).
interface jk_excite_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] i_target;
   logic             i_tvalid;
   logic             o_tready;
   logic [WIDTH-1:0] o_J;
   logic [WIDTH-1:0] o_K;
   logic             o_E;
   logic [WIDTH-1:0] i_Qfb;
   logic             i_clear_err;
   logic             o_busy;
   logic             o_err;

   modport slave (
      input  i_target, i_tvalid, i_Qfb, i_clear_err,
      output o_tready, o_J, o_K, o_E, o_busy, o_err
   );

   modport master (
      output i_target, i_tvalid, i_Qfb, i_clear_err,
      input  o_tready, o_J, o_K, o_E, o_busy, o_err
   );
endinterface

// File: rtl/jk_excite_fifo.sv
// Target word FIFO, DEPTH (power of 2) x WIDTH; full/empty come from a registered count.
// Storage is not reset: an empty count is enough to discard stale entries.
module jk_excite_fifo
   import jk_excite_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_head  = r_mem[r_rd_ptr];

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/jk_excite.sv
// Drives a bank of JK flops toward queued target words and checks their feedback.
// The shadow tracks what the bank should hold; a mismatch parks the FSM until acknowledged.
//   state  | meaning
//   IDLE   | waiting for a queued target
//   DRIVE  | E pulse with registered J/K
//   SETTLE | SETTLE_CYC quiet cycles
//   VERIFY | compare Qfb with shadow
//   ERROR  | stalled until clear_err
module jk_excite
   import jk_excite_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter int SETTLE_CYC  = 1,
   parameter int TOGGLE_MODE = 0
) (
   input  logic        i_clock,
   input  logic        i_reset,
   jk_excite_if.slave  bus
);
   localparam int SW = $clog2(SETTLE_CYC + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shadow;
   logic [WIDTH-1:0] r_target;
   logic [WIDTH-1:0] r_J;
   logic [WIDTH-1:0] r_K;
   logic             r_E;
   logic             r_err;
   logic             r_rdy_en;
   logic [SW-1:0]    r_settle;
   logic [WIDTH-1:0] w_head;
   logic [WIDTH-1:0] w_exc_j;
   logic [WIDTH-1:0] w_exc_k;
   logic             w_full;
   logic             w_empty;
   logic             w_tready;
   logic             w_push;
   logic             w_pop;
   logic             w_mismatch;
   logic             w_clear;

   assign w_tready   = r_rdy_en & ~w_full;
   assign w_push     = bus.i_tvalid & w_tready;
   assign w_mismatch = (bus.i_Qfb != r_shadow);
   assign w_clear    = (r_state == ST_ERROR) & bus.i_clear_err;

   assign bus.o_tready = w_tready;
   assign bus.o_J      = r_J;
   assign bus.o_K      = r_K;
   assign bus.o_E      = r_E;
   assign bus.o_err    = r_err;
   assign bus.o_busy   = (r_state != ST_IDLE) | ~w_empty;

   jk_excite_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (bus.i_target),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   // Excitation is taken from the FIFO head so J/K/E register on the popping edge.
   for (genvar g = 0; g < WIDTH; g++) begin : g_exc
      logic [1:0] w_code;
      assign w_code     = jk_code(r_shadow[g], w_head[g], TOGGLE_MODE != 0);
      assign w_exc_j[g] = w_code[1];
      assign w_exc_k[g] = w_code[0];
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_DRIVE;
            end
         end
         ST_DRIVE:  w_state_nxt = ST_SETTLE;
         ST_SETTLE: if (r_settle == '0) w_state_nxt = ST_VERIFY;
         ST_VERIFY: w_state_nxt = w_mismatch ? ST_ERROR : ST_IDLE;
         ST_ERROR:  if (bus.i_clear_err) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_shadow <= '0;
         r_target <= '0;
         r_J      <= '0;
         r_K      <= '0;
         r_E      <= 1'b0;
         r_err    <= 1'b0;
         r_rdy_en <= 1'b0;
         r_settle <= '0;
      end else begin
         r_rdy_en <= 1'b1;
         r_E      <= w_pop;
         r_J      <= w_pop ? w_exc_j : '0;
         r_K      <= w_pop ? w_exc_k : '0;
         if (w_pop)
            r_target <= w_head;

         if (r_state == ST_DRIVE)
            r_shadow <= r_target;
         else if (w_clear)
            r_shadow <= bus.i_Qfb;

         if (r_state == ST_DRIVE)
            r_settle <= SW'(SETTLE_CYC - 1);
         else if ((r_state == ST_SETTLE) && (r_settle != '0))
            r_settle <= r_settle - 1'b1;

         if ((r_state == ST_VERIFY) && w_mismatch)
            r_err <= 1'b1;
         else if (w_clear)
            r_err <= 1'b0;
      end
   end

endmodule
